// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_mem_pkg: shared types and widths for the unified memory port arbiter.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter_if: fetch/data requester handshakes plus the memory port.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if
    import cpu_mem_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) ();

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Requesters and memory macro side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_wait_counter: loadable down-counter with a zero flag, stops at zero.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module mem_wait_counter
    import cpu_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter: shares one fixed-latency memory port between fetch and MEM.
// Rev 1.0 - optional MEM_ARB_RR_EN selects round-robin on contested requests.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    arb_state_t    state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic w_any_req;
    logic w_grant_d;
    logic w_cnt_load;
    logic w_cnt_dec;
    logic w_cnt_zero;

    assign w_any_req = bus.if_req || bus.d_req;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    // On a contest the requester that did not win the previous grant goes first.
    assign w_grant_d = bus.d_req && (!bus.if_req || (last_q == OWNER_IF));

    always_comb begin
        last_d = last_q;
        if ((state_q == IDLE) && w_any_req) begin
            last_d = w_grant_d ? OWNER_D : OWNER_IF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= OWNER_IF;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // The pipeline is stalled in MEM, so data always beats fetch.
    assign w_grant_d = bus.d_req;
`endif

    assign w_cnt_load = (state_q == IDLE) && w_any_req;
    assign w_cnt_dec  = (state_q == BUSY) && !w_cnt_zero;

    mem_wait_counter u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cnt_load),
        .load_val (LAT_M1),
        .dec      (w_cnt_dec),
        .zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (w_any_req)  state_d = BUSY;
            BUSY:    if (w_cnt_zero) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if ((state_q == IDLE) && w_any_req) begin
            owner_d = w_grant_d ? OWNER_D : OWNER_IF;
            we_d    = w_grant_d && bus.d_we;
            addr_d  = w_grant_d ? bus.d_addr : bus.if_addr;
            wdata_d = w_grant_d ? bus.d_wdata : '0;
        end
        // Stores leave both read-data registers untouched.
        if ((state_q == BUSY) && w_cnt_zero && !we_q) begin
            if (owner_q == OWNER_D) begin
                d_rdata_d = bus.mem_rdata;
            end else begin
                if_rdata_d = bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= OWNER_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.if_ack    = 1'b0;
        bus.d_ack     = 1'b0;
        bus.busy      = (state_q != IDLE);
        unique case (state_q)
            BUSY: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
            end
            RESP: begin
                bus.if_ack = (owner_q == OWNER_IF);
                bus.d_ack  = (owner_q == OWNER_D);
            end
            default: ;
        endcase
    end

    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter: two arbiters (MEM_LAT 2 and 1) against a cycle-number model.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import cpu_mem_pkg::*;

    localparam int NI = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        s_if_req  [NI];
    logic [31:0] s_if_addr [NI];
    logic        s_d_req   [NI];
    logic        s_d_we    [NI];
    logic [31:0] s_d_addr  [NI];
    logic [31:0] s_d_wdata [NI];

    logic        m_if_ack   [NI];
    logic        m_d_ack    [NI];
    logic        m_mem_en   [NI];
    logic        m_mem_we   [NI];
    logic        m_busy     [NI];
    logic [31:0] m_mem_addr [NI];
    logic [31:0] m_mem_wdata[NI];
    logic [31:0] m_if_rdata [NI];
    logic [31:0] m_d_rdata  [NI];

    int edge_no [NI];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int LAT = (k == 0) ? 2 : 1;

        logic [31:0] mem [1024];
        int          en_run;

        mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

        mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.if_req  = s_if_req[k];
        assign bus.if_addr = s_if_addr[k];
        assign bus.d_req   = s_d_req[k];
        assign bus.d_we    = s_d_we[k];
        assign bus.d_addr  = s_d_addr[k];
        assign bus.d_wdata = s_d_wdata[k];

        assign m_if_ack[k]    = bus.if_ack;
        assign m_d_ack[k]     = bus.d_ack;
        assign m_mem_en[k]    = bus.mem_en;
        assign m_mem_we[k]    = bus.mem_we;
        assign m_busy[k]      = bus.busy;
        assign m_mem_addr[k]  = bus.mem_addr;
        assign m_mem_wdata[k] = bus.mem_wdata;
        assign m_if_rdata[k]  = bus.if_rdata;
        assign m_d_rdata[k]   = bus.d_rdata;

        // Memory macro: read data is only valid in the last cycle of the latency window.
        initial begin
            for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | (i << 2);
            mem[4] = 32'h0010_0093;
        end

        assign bus.mem_rdata = (bus.mem_en && (en_run == LAT - 1)) ? mem[bus.mem_addr[11:2]]
                                                                    : (32'hBAD0_0000 | en_run);

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                en_run <= 0;
            end else begin
                en_run <= bus.mem_en ? en_run + 1 : 0;
                if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
            end
        end

        // Model: an access granted at edge g strobes the memory for cycles g..g+LAT-1,
        // acks in the cycle after edge g+LAT, and the port is free again after g+LAT+1.
        bit          md_act;
        int          md_g;
        bit          md_owner;
        bit          md_we;
        logic [31:0] md_addr;
        logic [31:0] md_wdata;
        logic [31:0] md_ifr;
        logic [31:0] md_dr;
        bit          md_last;

        always @(posedge clk or posedge rst) begin
            int e;
            bit d_win;
            if (rst) begin
                md_act  <= 1'b0;
                md_ifr  <= '0;
                md_dr   <= '0;
                md_last <= 1'b0;
            end else begin
                e = edge_no[k] + 1;
                edge_no[k] <= e;
`ifdef MEM_ARB_RR_EN
                d_win = s_d_req[k] && (!s_if_req[k] || !md_last);
`else
                d_win = s_d_req[k];
`endif
                if (md_act && (e == md_g + LAT)) begin
                    if (!md_we) begin
                        if (md_owner) md_dr  <= mem[md_addr[11:2]];
                        else          md_ifr <= mem[md_addr[11:2]];
                    end
                end else if (md_act && (e == md_g + LAT + 1)) begin
                    md_act <= 1'b0;
                end else if (!md_act && (s_if_req[k] || s_d_req[k])) begin
                    md_act   <= 1'b1;
                    md_g     <= e;
                    md_owner <= d_win;
                    md_last  <= d_win;
                    md_we    <= d_win && s_d_we[k];
                    md_addr  <= d_win ? s_d_addr[k] : s_if_addr[k];
                    md_wdata <= s_d_wdata[k];
                end
            end
        end

        always @(negedge clk) begin
            int  e;
            bit  in_busy;
            bit  in_resp;
            e       = edge_no[k];
            in_busy = md_act && (e < md_g + LAT);
            in_resp = md_act && (e == md_g + LAT);
            chk1 ($sformatf("i%0d.busy", k),     bus.busy,     md_act);
            chk1 ($sformatf("i%0d.mem_en", k),   bus.mem_en,   in_busy);
            chk1 ($sformatf("i%0d.mem_we", k),   bus.mem_we,   in_busy && md_we);
            chk1 ($sformatf("i%0d.if_ack", k),   bus.if_ack,   in_resp && !md_owner);
            chk1 ($sformatf("i%0d.d_ack", k),    bus.d_ack,    in_resp && md_owner);
            chk32($sformatf("i%0d.if_rdata", k), bus.if_rdata, md_ifr);
            chk32($sformatf("i%0d.d_rdata", k),  bus.d_rdata,  md_dr);
            if (in_busy) begin
                chk32($sformatf("i%0d.mem_addr", k), bus.mem_addr, md_addr);
                if (md_we) chk32($sformatf("i%0d.mem_wdata", k), bus.mem_wdata, md_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered just after a rising edge with the request already raised; returns in the
    // IDLE cycle that follows the ack.
    task automatic wait_ack(input int k, input bit want_d, input string name,
                            output int edge_at, output int en_c, output int we_c);
        bit seen  = 1'b0;
        bit wrong = 1'b0;
        edge_at = -1;
        en_c    = 0;
        we_c    = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (m_mem_en[k]) en_c++;
            if (m_mem_en[k] && m_mem_we[k]) we_c++;
            if (want_d ? m_if_ack[k] : m_d_ack[k]) wrong = 1'b1;
            if (want_d ? m_d_ack[k] : m_if_ack[k]) begin
                seen    = 1'b1;
                edge_at = edge_no[k];
            end
        end
        chk1({name, ".ack_seen"}, seen, 1'b1);
        chk1({name, ".other_ack"}, wrong, 1'b0);
        tick();
    endtask

    task automatic access(input int k, input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input string name,
                          output int lat, output int en_c, output int we_c);
        int e0;
        int ea;
        e0 = edge_no[k];
        if (is_d) begin
            s_d_we[k]    = we;
            s_d_addr[k]  = addr;
            s_d_wdata[k] = wdata;
            s_d_req[k]   = 1'b1;
        end else begin
            s_if_addr[k] = addr;
            s_if_req[k]  = 1'b1;
        end
        wait_ack(k, is_d, name, ea, en_c, we_c);
        s_if_req[k] = 1'b0;
        s_d_req[k]  = 1'b0;
        s_d_we[k]   = 1'b0;
        lat = ea - e0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, en_c, we_c, ea, cnt, good, prev;
        bit seen;
        bit order [3];
        logic [31:0] t5_addr [4];
        logic [31:0] t5_data [4];
        t5_addr = '{32'h80, 32'h84, 32'h10, 32'h88};
        t5_data = '{32'hA500_0080, 32'hA500_0084, 32'h0010_0093, 32'hA500_0088};

        for (int k = 0; k < NI; k++) begin
            s_if_req[k] = 1'b0; s_if_addr[k] = '0; s_d_req[k] = 1'b0;
            s_d_we[k] = 1'b0; s_d_addr[k] = '0; s_d_wdata[k] = '0;
        end
        #1 rst = 1'b1;
        #2;
        for (int k = 0; k < NI; k++) begin
            chk1 ($sformatf("rst%0d.busy", k),   m_busy[k],   1'b0);
            chk1 ($sformatf("rst%0d.mem_en", k), m_mem_en[k], 1'b0);
            chk1 ($sformatf("rst%0d.mem_we", k), m_mem_we[k], 1'b0);
            chk32($sformatf("rst%0d.mem_addr", k),  m_mem_addr[k],  32'h0);
            chk32($sformatf("rst%0d.mem_wdata", k), m_mem_wdata[k], 32'h0);
            chk1 ($sformatf("rst%0d.if_ack", k), m_if_ack[k], 1'b0);
            chk1 ($sformatf("rst%0d.d_ack", k),  m_d_ack[k],  1'b0);
            chk32($sformatf("rst%0d.if_rdata", k), m_if_rdata[k], 32'h0);
            chk32($sformatf("rst%0d.d_rdata", k),  m_d_rdata[k],  32'h0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Contest straight after reset: both held until three acks have gone out.
        s_if_addr[0] = 32'h20;
        s_d_addr[0]  = 32'h104;
        s_if_req[0]  = 1'b1;
        s_d_req[0]   = 1'b1;
        cnt = 0;
        for (int i = 0; i < 80 && cnt < 3; i++) begin
            @(negedge clk);
            if (m_d_ack[0] || m_if_ack[0]) begin
                order[cnt] = m_d_ack[0];
                cnt++;
            end
        end
        chk32("contest.ack_count", cnt, 32'd3);
        chk1("contest.first_is_d", order[0], 1'b1);
`ifdef MEM_ARB_RR_EN
        chk1("contest.second_is_d", order[1], 1'b0);
`else
        chk1("contest.second_is_d", order[1], 1'b1);
`endif
        chk1("contest.third_is_d", order[2], 1'b1);
        tick();
        s_d_req[0] = 1'b0;
        wait_ack(0, 1'b0, "contest.if_after", ea, en_c, we_c);
        s_if_req[0] = 1'b0;
        tick();
        chk32("contest.d_rdata", m_d_rdata[0], 32'hA500_0104);
        chk32("contest.if_rdata", m_if_rdata[0], 32'hA500_0020);

        // Fetch-only access
        access(0, 1'b0, 1'b0, 32'h10, 32'h0, "fetch", lat, en_c, we_c);
        chk32("fetch.latency", lat, 32'd3);
        chk32("fetch.en_cycles", en_c, 32'd2);
        chk32("fetch.if_rdata", m_if_rdata[0], 32'h0010_0093);

        // Store, then read it back
        access(0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, "store", lat, en_c, we_c);
        chk32("store.latency", lat, 32'd3);
        chk32("store.we_cycles", we_c, 32'd2);
        chk32("store.d_rdata_kept", m_d_rdata[0], 32'hA500_0104);
        access(0, 1'b1, 1'b0, 32'h100, 32'h0, "load", lat, en_c, we_c);
        chk32("load.d_rdata", m_d_rdata[0], 32'hDEAD_BEEF);

        // Address change while the access is in flight
        s_d_we[0] = 1'b0; s_d_addr[0] = 32'h200; s_d_req[0] = 1'b1;
        seen = 1'b0; good = 0; cnt = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (m_mem_en[0]) begin
                cnt++;
                s_d_addr[0] = 32'h300;
                if (m_mem_addr[0] == 32'h200) good++;
            end
            if (m_d_ack[0]) seen = 1'b1;
        end
        tick();
        s_d_req[0] = 1'b0;
        tick();
        chk1 ("addrchg.ack_seen", seen, 1'b1);
        chk32("addrchg.addr_held", good, 32'd2);
        chk32("addrchg.en_cycles", cnt, 32'd2);
        chk32("addrchg.d_rdata", m_d_rdata[0], 32'hA500_0200);

        // Reset in the second BUSY cycle
        s_if_addr[0] = 32'h40; s_if_req[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (m_mem_en[0]) seen = 1'b1;
        end
        chk1("midrst.started", seen, 1'b1);
        tick();
        chk1("midrst.busy2_en", m_mem_en[0], 1'b1);
        #1 rst = 1'b1;
        #1;
        chk1("midrst.mem_en", m_mem_en[0], 1'b0);
        chk1("midrst.busy", m_busy[0], 1'b0);
        chk1("midrst.mem_we", m_mem_we[0], 1'b0);
        s_if_req[0] = 1'b0;
        tick();
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (m_if_ack[0] || m_d_ack[0]) cnt++;
        end
        chk32("midrst.no_ack", cnt, 32'd0);
        tick();
        access(0, 1'b0, 1'b0, 32'h40, 32'h0, "postrst", lat, en_c, we_c);
        chk32("postrst.latency", lat, 32'd3);
        chk32("postrst.if_rdata", m_if_rdata[0], 32'hA500_0040);

        // MEM_LAT=1, fetch held high, address refreshed for each grant
        s_if_addr[1] = t5_addr[0];
        s_if_req[1]  = 1'b1;
        prev = 0;
        for (int a = 0; a < 4; a++) begin
            seen = 1'b0; en_c = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (m_mem_en[1]) en_c++;
                if (m_if_ack[1]) begin
                    seen = 1'b1;
                    ea   = edge_no[1];
                end
            end
            chk1 ($sformatf("b2b%0d.ack_seen", a), seen, 1'b1);
            chk32($sformatf("b2b%0d.en_cycles", a), en_c, 32'd1);
            chk32($sformatf("b2b%0d.if_rdata", a), m_if_rdata[1], t5_data[a]);
            if (a > 0) chk32($sformatf("b2b%0d.spacing", a), ea - prev, 32'd3);
            prev = ea;
            if (a < 3) s_if_addr[1] = t5_addr[a + 1];
            else       s_if_req[1]  = 1'b0;
        end
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
